// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register pending-write counters that gate instruction issue in decode
module reg_scoreboard #(
  parameter int NREG = 32,
  parameter int AW = 5,
  parameter int CNT_W = 2,
  parameter int NSRC = 2,
  parameter int NWB = 3,
  parameter int BYPASS = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  flush,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic                  issue_we,
  input  logic [AW-1:0]         issue_waddr,
  input  logic [NSRC*AW-1:0]    issue_src_addr,
  input  logic [NSRC-1:0]       issue_src_need,
  input  logic [NWB-1:0]        cmp_valid,
  input  logic [NWB*AW-1:0]     cmp_addr,
  output logic [NSRC-1:0]       src_busy,
  output logic                  dst_full,
  output logic [AW+CNT_W-1:0]   total_pending,
  output logic                  err_underflow
);
  localparam int CMAX = 2**CNT_W - 1;
  localparam int DW = CNT_W + 2 + $clog2(NWB + 1);
  localparam int TW = AW + CNT_W;
  logic [CNT_W-1:0] cnt [NREG];
  logic [CNT_W-1:0] cnt_nxt [NREG];
  logic [DW-1:0] dec [NREG];
  logic [DW-1:0] sum_r, app_r;
  logic [TW-1:0] tp_nxt, cnt_sum;
  logic uf, accept;
  // count same-cycle completions per register; r0 is never tracked
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      dec[r] = '0;
      for (int j = 0; j < NWB; j++)
        if (r != 0 && cmp_valid[j] && cmp_addr[j*AW +: AW] == AW'(r)) dec[r] = dec[r] + DW'(1);
    end
  end
  // source hazards; with a forwarding path, completions this cycle resolve the hazard
  always_comb begin
    src_busy = '0;
    for (int i = 0; i < NSRC; i++)
      src_busy[i] = issue_src_need[i] && issue_src_addr[i*AW +: AW] != '0 &&
                    (BYPASS != 0 ? DW'(cnt[issue_src_addr[i*AW +: AW]]) > dec[issue_src_addr[i*AW +: AW]]
                                 : cnt[issue_src_addr[i*AW +: AW]] != '0);
  end
  assign dst_full = issue_we && issue_waddr != '0 && cnt[issue_waddr] == CNT_W'(CMAX);
  assign issue_ready = ~|src_busy & ~dst_full;
  assign accept = issue_valid & issue_ready;
  // net per-register update: excess completions are dropped and flagged, counters floor at 0
  always_comb begin
    uf = 1'b0;
    sum_r = '0;
    app_r = '0;
    tp_nxt = total_pending;
    for (int r = 0; r < NREG; r++) begin
      sum_r = DW'(cnt[r]) + DW'(accept && issue_we && r != 0 && issue_waddr == AW'(r));
      app_r = dec[r] > sum_r ? sum_r : dec[r];
      uf = uf | (dec[r] > sum_r);
      cnt_nxt[r] = r == 0 ? '0 : CNT_W'(sum_r - app_r);
      tp_nxt = tp_nxt + TW'(cnt_nxt[r]) - TW'(cnt[r]);
    end
  end
  // state registers; flush drops all pending work but keeps the sticky error
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt <= '{default: '0};
      total_pending <= '0;
      err_underflow <= 1'b0;
    end else if (flush) begin
      cnt <= '{default: '0};
      total_pending <= '0;
    end else begin
      cnt <= cnt_nxt;
      total_pending <= tp_nxt;
      err_underflow <= err_underflow | uf;
    end
  end
  // running total must always equal the sum of all counters
  always_comb begin
    cnt_sum = '0;
    for (int r = 0; r < NREG; r++) cnt_sum = cnt_sum + TW'(cnt[r]);
  end
  a_total: assert property (@(posedge clk) disable iff (!resetn) total_pending == cnt_sum);
  a_r0: assert property (@(posedge clk) cnt[0] == '0);
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: directed checks of issue gating, saturation, underflow and flush
module tb_reg_scoreboard;
  logic clk = 1'b0;
  logic resetn, flush, issue_valid, issue_we;
  logic [4:0] issue_waddr;
  logic [9:0] issue_src_addr;
  logic [1:0] issue_src_need;
  logic [2:0] cmp_valid;
  logic [14:0] cmp_addr;
  logic ready_b, full_b, err_b, ready_n, full_n, err_n;
  logic [1:0] busy_b, busy_n;
  logic [6:0] total_b, total_n;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  reg_scoreboard #(.BYPASS(1)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .issue_valid(issue_valid), .issue_ready(ready_b),
    .issue_we(issue_we), .issue_waddr(issue_waddr), .issue_src_addr(issue_src_addr),
    .issue_src_need(issue_src_need), .cmp_valid(cmp_valid), .cmp_addr(cmp_addr),
    .src_busy(busy_b), .dst_full(full_b), .total_pending(total_b), .err_underflow(err_b)
  );
  reg_scoreboard #(.BYPASS(0)) dut_nb (
    .clk(clk), .resetn(resetn), .flush(flush), .issue_valid(issue_valid), .issue_ready(ready_n),
    .issue_we(issue_we), .issue_waddr(issue_waddr), .issue_src_addr(issue_src_addr),
    .issue_src_need(issue_src_need), .cmp_valid(cmp_valid), .cmp_addr(cmp_addr),
    .src_busy(busy_n), .dst_full(full_n), .total_pending(total_n), .err_underflow(err_n)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [4:0] a);
    issue_valid = 1'b1;
    issue_we = 1'b1;
    issue_waddr = a;
    tick();
  endtask
  initial begin
    resetn = 1'b0;
    flush = 1'b0;
    issue_valid = 1'b0;
    issue_we = 1'b0;
    issue_waddr = '0;
    issue_src_addr = '0;
    issue_src_need = '0;
    cmp_valid = '0;
    cmp_addr = '0;
    repeat (2) tick();
    resetn = 1'b1;
    issue_valid = 1'b1;
    issue_src_addr = {5'd4, 5'd3};
    issue_src_need = 2'b11;
    #1;
    chk("rst_ready", ready_b, 1);
    chk("rst_busy", busy_b, 0);
    chk("rst_full", full_b, 0);
    chk("rst_total", total_b, 0);
    chk("rst_err", err_b, 0);
    tick();
    issue_src_need = 2'b00;
    issue(5'd5);
    issue_we = 1'b0;
    issue_src_addr = {5'd0, 5'd5};
    issue_src_need = 2'b01;
    #1;
    chk("raw_busy", busy_b, 2'b01);
    chk("raw_ready", ready_b, 0);
    chk("raw_ready_nb", ready_n, 0);
    chk("raw_total", total_b, 1);
    cmp_valid = 3'b001;
    cmp_addr = {5'd0, 5'd0, 5'd5};
    #1;
    chk("byp_ready", ready_b, 1);
    chk("byp_busy", busy_b, 0);
    chk("nobyp_ready", ready_n, 0);
    tick();
    cmp_valid = '0;
    #1;
    chk("nobyp_ready_late", ready_n, 1);
    chk("cmp_total", total_b, 0);
    issue_src_need = 2'b00;
    issue(5'd7);
    issue(5'd7);
    issue(5'd7);
    chk("sat_full", full_b, 1);
    chk("sat_ready", ready_b, 0);
    chk("sat_total", total_b, 3);
    cmp_valid = 3'b001;
    cmp_addr = {5'd0, 5'd0, 5'd7};
    #1;
    chk("sat_cmp_still_full", full_b, 1);
    chk("sat_cmp_stall", ready_b, 0);
    tick();
    cmp_valid = '0;
    #1;
    chk("sat_ready_after", ready_b, 1);
    chk("sat_total_after", total_b, 2);
    issue_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_total", total_b, 0);
    issue(5'd9);
    chk("r9_total", total_b, 1);
    cmp_valid = 3'b011;
    cmp_addr = {5'd0, 5'd9, 5'd9};
    issue(5'd9);
    cmp_valid = '0;
    issue_valid = 1'b0;
    issue_we = 1'b0;
    issue_src_addr = {5'd0, 5'd9};
    issue_src_need = 2'b01;
    #1;
    chk("net_total", total_b, 0);
    chk("net_err", err_b, 0);
    chk("net_busy", busy_b, 0);
    cmp_valid = 3'b100;
    cmp_addr = {5'd12, 5'd0, 5'd0};
    tick();
    cmp_valid = '0;
    chk("uf_err", err_b, 1);
    chk("uf_total", total_b, 0);
    issue_src_addr = {5'd0, 5'd12};
    #1;
    chk("uf_busy", busy_b, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("uf_sticky", err_b, 1);
    issue_src_need = 2'b00;
    issue(5'd1);
    issue(5'd2);
    issue(5'd3);
    issue(5'd3);
    chk("mid_total", total_b, 4);
    flush = 1'b1;
    issue(5'd4);
    flush = 1'b0;
    issue_valid = 1'b0;
    chk("fl_total", total_b, 0);
    issue_src_addr = {5'd3, 5'd4};
    issue_src_need = 2'b11;
    #1;
    chk("fl_busy", busy_b, 0);
    issue_src_addr = {5'd0, 5'd0};
    issue(5'd0);
    chk("r0_busy", busy_b, 0);
    chk("r0_ready", ready_b, 1);
    chk("r0_full", full_b, 0);
    chk("r0_total", total_b, 0);
    issue_valid = 1'b0;
    tick();
    chk("end_total", total_b, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
